// File: rtl/xbus_arbiter.sv
// xbus_arbiter: round-robin owner arbitration for the shared 36-bit xbus.
// Grants one internal requester at a time, drives the pad output enable,
// inserts tristated turnaround cycles between owners and samples the bus
// while nobody drives it. Host direction (host_dir=1) blocks new grants
// and revokes the current one.
// Optional feature macro: XBUS_ARB_TIMEOUT_EN adds the hold counter,
// forced revoke after MAX_HOLD cycles, the re-request mask and the
// timeout pulse. Without it, timeout is tied low and MAX_HOLD is unused.
module xbus_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 36,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 1024
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    host_dir,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [WIDTH-1:0]        bus_in,
  output logic [NREQ-1:0]         grant,
  output logic [2:0]              owner_id,
  output logic                    bus_oe,
  output logic [WIDTH-1:0]        bus_out,
  output logic [WIDTH-1:0]        sample_data,
  output logic                    busy,
  output logic                    timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_e;

  // Out-of-range parameters stop elaboration rather than build a broken arbiter.
  if (NREQ < 2 || NREQ > 8 || TURN_CYC < 0 || TURN_CYC > 15 || MAX_HOLD < 1) begin : g_param_chk
    $error("xbus_arbiter: parameter out of range");
  end

  state_e             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [2:0]         owner_q, owner_d;
  logic [2:0]         ptr_q, ptr_d;
  logic               oe_q, oe_d;
  logic [WIDTH-1:0]   bus_out_q, bus_out_d;
  logic [WIDTH-1:0]   sample_q, sample_d;
  logic [3:0]         turn_q, turn_d;

  logic [NREQ-1:0]    elig;
  logic [2:0]         win, win_hi, win_lo;
  logic               win_vld, vld_hi, vld_lo;
  logic [WIDTH-1:0]   win_data, own_data;
  logic               own_req;

`ifdef XBUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NREQ-1:0]    mask_q, mask_d;
  logic               tmo_q, tmo_d;
  logic               hold_hit;

  assign elig     = req & ~mask_q;
  assign hold_hit = (hold_q == HOLD_W'(MAX_HOLD));
  assign timeout  = tmo_q;
`else
  assign elig     = req;
  assign timeout  = 1'b0;
`endif

  // Round-robin pick: lowest eligible index above ptr, else lowest at/below ptr.
  always_comb begin
    win_hi = '0;
    vld_hi = 1'b0;
    win_lo = '0;
    vld_lo = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        if (3'(i) > ptr_q) begin
          win_hi = 3'(i);
          vld_hi = 1'b1;
        end else begin
          win_lo = 3'(i);
          vld_lo = 1'b1;
        end
      end
    end
    win     = vld_hi ? win_hi : win_lo;
    win_vld = vld_hi | vld_lo;
  end

  // Data and request muxes for the arbitration winner and the current owner.
  always_comb begin
    win_data = '0;
    own_data = '0;
    own_req  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 3'(i))     win_data = req_data[i*WIDTH +: WIDTH];
      if (owner_q == 3'(i)) begin
        own_data = req_data[i*WIDTH +: WIDTH];
        own_req  = req[i];
      end
    end
  end

  // Next-state and registered-output logic for IDLE / GRANT / TURN.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    bus_out_d = bus_out_q;
    sample_d  = sample_q;
    turn_d    = turn_q;
`ifdef XBUS_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    tmo_d     = 1'b0;
    // A revoked requester becomes eligible again once its req is seen low.
    mask_d    = mask_q & req;
`endif
    case (state_q)
      S_IDLE: begin
        sample_d = bus_in;
        grant_d  = '0;
        oe_d     = 1'b0;
        if (!host_dir && win_vld) begin
          grant_d   = NREQ'(1) << win;
          owner_d   = win;
          ptr_d     = win;
          oe_d      = 1'b1;
          bus_out_d = win_data;
          state_d   = S_GRANT;
`ifdef XBUS_ARB_TIMEOUT_EN
          hold_d    = HOLD_W'(1);
`endif
        end
      end
      S_GRANT: begin
        bus_out_d = own_data;
`ifdef XBUS_ARB_TIMEOUT_EN
        // Release wins over a coincident hold limit: no pulse, no mask.
        if (own_req && hold_hit) begin
          tmo_d  = 1'b1;
          mask_d = mask_d | (NREQ'(1) << owner_q);
        end
        if (!own_req || host_dir || hold_hit) begin
`else
        if (!own_req || host_dir) begin
`endif
          grant_d   = '0;
          oe_d      = 1'b0;
          bus_out_d = '0;
          turn_d    = 4'(TURN_CYC);
          state_d   = (TURN_CYC == 0) ? S_IDLE : S_TURN;
        end
`ifdef XBUS_ARB_TIMEOUT_EN
        else begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      S_TURN: begin
        oe_d   = 1'b0;
        turn_d = turn_q - 4'd1;
        if (turn_q <= 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset releases the bus immediately with no turnaround.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= 3'(NREQ - 1);
      oe_q      <= 1'b0;
      bus_out_q <= '0;
      sample_q  <= '0;
      turn_q    <= '0;
`ifdef XBUS_ARB_TIMEOUT_EN
      hold_q    <= '0;
      mask_q    <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      bus_out_q <= bus_out_d;
      sample_q  <= sample_d;
      turn_q    <= turn_d;
`ifdef XBUS_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign owner_id    = owner_q;
  assign bus_oe      = oe_q;
  assign bus_out     = bus_out_q;
  assign sample_data = sample_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter (NREQ=4, TURN_CYC=2, MAX_HOLD=8).
module tb_xbus_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 36;

  logic              gclk = 1'b0;
  logic              grst_n;
  logic              host_dir;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [W-1:0]      bus_in;
  logic [NREQ-1:0]   grant;
  logic [2:0]        owner_id;
  logic              bus_oe;
  logic [W-1:0]      bus_out;
  logic [W-1:0]      sample_data;
  logic              busy;
  logic              timeout;

  int n_cmp = 0;
  int n_bad = 0;

  xbus_arbiter #(.NREQ(NREQ), .WIDTH(W), .TURN_CYC(2), .MAX_HOLD(8)) dut (
    .sys_clk(gclk), .reset_n(grst_n), .host_dir(host_dir), .req(req),
    .req_data(req_data), .bus_in(bus_in), .grant(grant), .owner_id(owner_id),
    .bus_oe(bus_oe), .bus_out(bus_out), .sample_data(sample_data),
    .busy(busy), .timeout(timeout)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic do_reset();
    grst_n = 1'b0;
    #3;
    step();
    grst_n = 1'b1;
  endtask

  initial begin
    int gap;
    int w;
    logic drop_seen;
    logic tmo_seen;
    host_dir = 1'b0;
    req      = '0;
    req_data = '0;
    bus_in   = '0;
    grst_n   = 1'b0;
    #2;

    // reset state
    chk("rst_grant", grant, 0);
    chk("rst_oe", bus_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_bus_out", bus_out, 0);
    chk("rst_sample", sample_data, 0);
    chk("rst_owner", owner_id, 0);
    step();
    grst_n = 1'b1;

    // single requester, data and sample behaviour
    bus_in = 36'h111111111;
    step();
    chk("idle_sample", sample_data, 36'h111111111);
    req = 4'b0001;
    req_data[0 +: W] = 36'h123456789;
    bus_in = 36'h222222222;
    step();
    chk("g0_grant", grant, 4'b0001);
    chk("g0_oe", bus_oe, 1);
    chk("g0_bus_out", bus_out, 36'h123456789);
    chk("g0_owner", owner_id, 0);
    chk("g0_busy", busy, 1);
    chk("g0_sample", sample_data, 36'h222222222);
    bus_in = 36'h333333333;
    req_data[0 +: W] = 36'h0000ABCDE;
    step();
    chk("g0_data_lat", bus_out, 36'h0000ABCDE);
    chk("grant_nosample", sample_data, 36'h222222222);
    req = 4'b0000;
    step();
    chk("rel_grant", grant, 0);
    chk("rel_oe", bus_oe, 0);
    chk("rel_bus_out", bus_out, 0);
    chk("turn_busy1", busy, 1);
    step();
    chk("turn_busy2", busy, 1);
    chk("turn_nosample", sample_data, 36'h222222222);
    step();
    chk("idle_busy", busy, 0);
    step();
    chk("idle_resample", sample_data, 36'h333333333);

    // round robin with all requesting, 3-cycle holds
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 36'hA00000000 + 36'(i);
    req = 4'b1111;
    step();
    chk("rr_first", grant, 4'b0001);
    for (int i = 0; i < NREQ; i++) begin
      w = i;
      step();
      chk("rr_hold", grant, 64'(1) << w);
      chk("rr_data", bus_out, 36'hA00000000 + 36'(w));
      step();
      req[w] = 1'b0;
      step();
      chk("rr_drop", bus_oe, 0);
      req[w] = 1'b1;
      gap = 0;
      while (!bus_oe && gap < 20) begin
        gap++;
        step();
      end
      chk("rr_gap", gap, 3);
      chk("rr_next", grant, 64'(1) << ((w + 1) % NREQ));
      chk("rr_owner", owner_id, (w + 1) % NREQ);
    end

    // host override while owner 2 holds the bus
    do_reset();
    req = 4'b0100;
    step();
    chk("ho_g2", grant, 4'b0100);
    req = 4'b1111;
    host_dir = 1'b1;
    step();
    chk("ho_drop_grant", grant, 0);
    chk("ho_drop_oe", bus_oe, 0);
    chk("ho_turn1", busy, 1);
    step();
    chk("ho_turn2", busy, 1);
    step();
    chk("ho_idle", busy, 0);
    drop_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (grant != 0) drop_seen = 1'b1;
    end
    chk("ho_blocked", drop_seen, 0);
    host_dir = 1'b0;
    step();
    chk("ho_g3", grant, 4'b1000);
    chk("ho_owner3", owner_id, 3);

`ifdef XBUS_ARB_TIMEOUT_EN
    // forced revoke after 8 cycles of ownership
    do_reset();
    req = 4'b0001;
    step();
    chk("to_grant", grant, 4'b0001);
    for (int k = 1; k < 8; k++) begin
      step();
      chk("to_hold_oe", bus_oe, 1);
      chk("to_no_pulse", timeout, 0);
    end
    step();
    chk("to_drop_oe", bus_oe, 0);
    chk("to_pulse", timeout, 1);
    step();
    chk("to_pulse_end", timeout, 0);
    drop_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (grant != 0) drop_seen = 1'b1;
    end
    chk("to_masked", drop_seen, 0);
    req = 4'b0000;
    step();
    req = 4'b0001;
    step();
    chk("to_regrant", grant, 4'b0001);
`else
    // no hold limit: ownership persists
    do_reset();
    req = 4'b0001;
    step();
    chk("nt_grant", grant, 4'b0001);
    drop_seen = 1'b0;
    tmo_seen  = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (grant != 4'b0001 || !bus_oe) drop_seen = 1'b1;
      if (timeout) tmo_seen = 1'b1;
    end
    chk("nt_no_drop", drop_seen, 0);
    chk("nt_no_tmo", tmo_seen, 0);
`endif

    // asynchronous reset in the middle of a grant
    do_reset();
    req = 4'b0010;
    step();
    chk("ar_g1", grant, 4'b0010);
    step();
    #2;
    grst_n = 1'b0;
    #1;
    chk("ar_oe", bus_oe, 0);
    chk("ar_grant", grant, 0);
    chk("ar_busy", busy, 0);
    req = 4'b0011;
    step();
    grst_n = 1'b1;
    step();
    chk("ar_first0", grant, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/xbus_arbiter.md
# xbus_arbiter

Shares the bidirectional 36-bit expansion bus (xbus) between up to NREQ internal requesters and the host direction control from WireIn 0x1F bit 0. The block grants bus ownership round-robin and drives the bus output enable. It inserts tristated turnaround cycles between owners and samples the bus when no one drives it. It sits between the requesting logic and the top-level tristate assignment of xbusp/xbusn.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 36: bus width.
- TURN_CYC, 2: tristated dead cycles after each release, 0..15.
- MAX_HOLD, 1024: grant cycle limit, used only with XBUS_ARB_TIMEOUT_EN, ≥1.
- sys_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- host_dir  in  1  WireIn 0x1F bit 0; 1 = host wants bus released (input mode).
- req  in  NREQ  per-requester level request; held high while ownership is wanted.
- req_data  in  NREQ*WIDTH  requester i's drive data at [i*WIDTH +: WIDTH].
- bus_in  in  WIDTH  pad input value of the bus.
- grant  out  NREQ  one-hot grant, registered.
- owner_id  out  3  index of current owner, valid while grant≠0.
- bus_oe  out  1  1 = top level drives bus_out onto the pads.
- bus_out  out  WIDTH  registered drive data.
- sample_data  out  WIDTH  registered bus_in, captured in IDLE.
- busy  out  1  state ≠ IDLE.
- timeout  out  1  one-cycle pulse on forced revoke.

## Operation
- States: IDLE, GRANT, TURN.
- IDLE: bus_oe=0, grant=0.
  - sample_data <= bus_in every cycle.
  - If host_dir=0 and any eligible req is set: pick the first set bit searching from ptr+1 mod NREQ upward.
  - Same edge: grant[w]=1, owner_id=w, bus_oe=1, bus_out <= req_data[w], ptr <= w. Go to GRANT.
- GRANT: bus_out <= req_data[owner] each cycle. Exit to TURN on any of:
  - req[owner]=0 (release)
  - host_dir=1 (host override)
  - hold count reaching MAX_HOLD (when compiled in)
- On exit edge: grant=0, bus_oe=0, bus_out=0, turn counter loaded with TURN_CYC.
- TURN: bus_oe=0; sample_data is not updated.
  - Counter decrements each cycle; go to IDLE when it reaches 0.
  - If TURN_CYC=0, the exit goes straight to IDLE.
- Eligibility: a requester revoked by timeout is masked until its req is seen low for ≥1 cycle. All others are eligible whenever req=1.
- host_dir=1 blocks all new grants in every state; it does not shorten TURN.
- Simultaneous release and timeout in the same cycle: treated as a release, no timeout pulse.
- req dropping during TURN, or req changes for non-owners: no effect until arbitration in IDLE.

## Timing
- Reset values (asynchronous, immediate on reset_n low):
  - state=IDLE, grant=0, owner_id=0, bus_oe=0, bus_out=0, sample_data=0, busy=0, timeout=0.
  - ptr=NREQ-1, so requester 0 has first priority.
  - Hold/turn counters 0; eligibility mask cleared.
- Reset mid-grant: bus released the same instant; no turnaround is performed.
- Grant latency: req sampled high at edge n in IDLE → grant/bus_oe high after edge n.
- Data latency: bus_out reflects req_data one cycle late.
- Release latency: req low at edge n → grant/bus_oe low after edge n.
- Minimum bus_oe-low gap between consecutive owners: TURN_CYC+1 cycles (TURN plus the IDLE arbitration cycle).
- Maximum hold is MAX_HOLD cycles with bus_oe=1. The timeout pulse coincides with the grant-drop edge.

## Configuration
- XBUS_ARB_TIMEOUT_EN defined: hold counter, timeout revoke, eligibility mask and timeout pulse are present. MAX_HOLD is honoured.
- XBUS_ARB_TIMEOUT_EN undefined: no hold counter and no mask. Grants last until release or host_dir=1. The timeout port is tied to 0. MAX_HOLD is ignored.

## Test plan
All scenarios use NREQ=4, TURN_CYC=2, MAX_HOLD=8.
- Reset, then req=4'b0001 with data0=36'h123456789: grant=0001 one cycle after req. bus_out=36'h123456789 and bus_oe=1 from the same edge. sample_data tracks bus_in only while in IDLE.
- req=4'b1111 held, each owner releases after 3 cycles: grant order 0,1,2,3,0. bus_oe low for exactly 3 cycles between owners.
- Owner 2 granted, host_dir raised: grant and bus_oe drop on the next edge. No new grant while host_dir=1, even with req=4'b1111. Lowering host_dir gives a grant to 3 after TURN and arbitration.
- With timeout compiled in, req=4'b0001 held for 20 cycles: bus_oe high 8 cycles, then timeout pulses one cycle. Requester 0 is not regranted until req drops and rises again.
- reset_n asserted asynchronously mid-GRANT between clock edges: bus_oe, grant and busy go 0 immediately. After release, requester 0 wins first.
- With timeout compiled out, req=4'b0001 held for 2000 cycles: grant never drops and timeout stays 0.
